// File: rtl/usb_cmd_rx.sv
// usb_cmd_rx: parses ASCII duty-set commands from the USB CDC out-pipeline.
// Line grammar: {R|G|B} HEX{NDIG} {CR|LF}, or X {CR|LF}. Each line is case-insensitive.
// Success raises a one-cycle cmd_ok pulse. A malformed line raises a one-cycle cmd_err pulse.
module usb_cmd_rx #(
   parameter int NDIG  = 2,
   parameter int ERR_W = 8,
   localparam int DW   = 4 * NDIG
) (
   input  logic             clk_48mhz,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic [DW-1:0]    red_duty,
   output logic [DW-1:0]    green_duty,
   output logic [DW-1:0]    blue_duty,
   output logic             cmd_ok,
   output logic             cmd_err,
   output logic [15:0]      rx_count,
   output logic [ERR_W-1:0] err_count
);

   localparam int CW = $clog2(NDIG + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {S_CMD, S_HEX, S_TERM, S_SKIP} state_t;
   typedef enum logic [1:0] {T_RED, T_GREEN, T_BLUE, T_ALL} target_t;

   state_t            r_state;
   target_t           r_target;
   logic [DW-1:0]     r_acc;
   logic [CW-1:0]     r_cnt;
   logic              r_ready;
   logic [DW-1:0]     r_red, r_green, r_blue;
   logic              r_ok, r_err;
   logic [15:0]       r_rx_count;
   logic [ERR_W-1:0]  r_err_count;

   logic              w_accept;
   logic              w_is_term, w_is_space, w_is_hex;
   logic              w_is_r, w_is_g, w_is_b, w_is_x;
   logic [3:0]        w_nib;
   logic              w_err;

   assign w_accept = rx_valid && r_ready;

   // Classify the incoming byte. Bytes with bit 7 set match no class.
   always_comb begin
      w_is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
      w_is_space = (rx_data == 8'h20);
      w_is_r     = (rx_data == 8'h52) || (rx_data == 8'h72);
      w_is_g     = (rx_data == 8'h47) || (rx_data == 8'h67);
      w_is_b     = (rx_data == 8'h42) || (rx_data == 8'h62);
      w_is_x     = (rx_data == 8'h58) || (rx_data == 8'h78);
      w_is_hex   = 1'b0;
      w_nib      = '0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
         w_is_hex = 1'b1;
         w_nib    = rx_data[3:0];
      end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                   (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
         w_is_hex = 1'b1;
         w_nib    = rx_data[3:0] + 4'd9;
      end
   end

   // Flag an accepted byte that is illegal in the current state. S_SKIP never flags.
   always_comb begin
      w_err = 1'b0;
      if (w_accept) begin
         unique case (r_state)
            S_CMD:  w_err = !(w_is_term || w_is_space || w_is_r || w_is_g || w_is_b || w_is_x);
            S_HEX:  w_err = !w_is_hex;
            S_TERM: w_err = !w_is_term;
            S_SKIP: w_err = 1'b0;
         endcase
      end
   end

   // Parser FSM, duty registers, pulses and counters.
   always_ff @(posedge clk_48mhz) begin
      if (!reset) begin
         r_state     <= S_CMD;
         r_target    <= T_RED;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ready     <= 1'b0;
         r_red       <= '0;
         r_green     <= '0;
         r_blue      <= '0;
         r_ok        <= 1'b0;
         r_err       <= 1'b0;
         r_rx_count  <= '0;
         r_err_count <= '0;
      end else begin
         r_ready <= 1'b1;
         r_ok    <= 1'b0;
         r_err   <= w_err;
         if (w_err && (r_err_count != '1))
            r_err_count <= r_err_count + ERR_W'(1);
         if (w_accept) begin
            r_rx_count <= r_rx_count + 16'd1;
            unique case (r_state)
               S_CMD: begin
                  if (w_is_r || w_is_g || w_is_b) begin
                     r_target <= w_is_r ? T_RED : (w_is_g ? T_GREEN : T_BLUE);
                     r_acc    <= '0;
                     r_cnt    <= '0;
                     r_state  <= S_HEX;
                  end else if (w_is_x) begin
                     r_target <= T_ALL;
                     r_state  <= S_TERM;
                  end else if (!(w_is_term || w_is_space)) begin
                     r_state  <= S_SKIP;
                  end
               end
               S_HEX: begin
                  if (w_is_hex) begin
                     r_acc <= {r_acc[DW-5:0], w_nib};
                     r_cnt <= r_cnt + CNT_ONE;
                     if (r_cnt == CNT_LAST)
                        r_state <= S_TERM;
                  end else if (w_is_term) begin
                     r_state <= S_CMD;
                  end else begin
                     r_state <= S_SKIP;
                  end
               end
               S_TERM: begin
                  if (w_is_term) begin
                     r_ok    <= 1'b1;
                     r_state <= S_CMD;
                     unique case (r_target)
                        T_RED:   r_red   <= r_acc;
                        T_GREEN: r_green <= r_acc;
                        T_BLUE:  r_blue  <= r_acc;
                        T_ALL: begin
                           r_red   <= '0;
                           r_green <= '0;
                           r_blue  <= '0;
                        end
                     endcase
                  end else begin
                     r_state <= S_SKIP;
                  end
               end
               S_SKIP: begin
                  if (w_is_term)
                     r_state <= S_CMD;
               end
            endcase
         end
      end
   end

   assign rx_ready   = r_ready;
   assign red_duty   = r_red;
   assign green_duty = r_green;
   assign blue_duty  = r_blue;
   assign cmd_ok     = r_ok;
   assign cmd_err    = r_err;
   assign rx_count   = r_rx_count;
   assign err_count  = r_err_count;

endmodule

// File: tb/tb_usb_cmd_rx.sv
// tb_usb_cmd_rx: directed checks of the usb_cmd_rx command parser.
module tb_usb_cmd_rx;

   logic        clk_48mhz = 1'b0;
   logic        reset     = 1'b0;
   logic [7:0]  rx_data   = '0;
   logic        rx_valid  = 1'b0;
   logic        rx_ready;
   logic [7:0]  red_duty, green_duty, blue_duty;
   logic        cmd_ok, cmd_err;
   logic [15:0] rx_count;
   logic [7:0]  err_count;

   int n_cmp = 0;
   int n_err = 0;

   usb_cmd_rx #(.NDIG(2), .ERR_W(8)) dut (
      .clk_48mhz  (clk_48mhz),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .red_duty   (red_duty),
      .green_duty (green_duty),
      .blue_duty  (blue_duty),
      .cmd_ok     (cmd_ok),
      .cmd_err    (cmd_err),
      .rx_count   (rx_count),
      .err_count  (err_count)
   );

   always #10 clk_48mhz = ~clk_48mhz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_48mhz);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
   endtask

   // pat holds one char per byte: '.' no pulse, 'O' cmd_ok, 'E' cmd_err.
   task automatic send_line(input string tag, input string s, input string pat);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i]);
         chk($sformatf("%s.ok%0d", tag, i),  {31'b0, cmd_ok},  {31'b0, pat[i] == "O"});
         chk($sformatf("%s.err%0d", tag, i), {31'b0, cmd_err}, {31'b0, pat[i] == "E"});
      end
   endtask

   initial begin
      // Reset held four cycles: all outputs low.
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("rst.ready%0d", i), {31'b0, rx_ready}, 32'h0);
         chk($sformatf("rst.duty%0d", i), {8'h0, red_duty, green_duty, blue_duty}, 32'h0);
         chk($sformatf("rst.pulse%0d", i), {30'b0, cmd_ok, cmd_err}, 32'h0);
         chk($sformatf("rst.cnt%0d", i), {8'h0, rx_count, err_count}, 32'h0);
      end
      reset = 1'b1;
      tick();
      chk("rel.ready", {31'b0, rx_ready}, 32'h1);
      chk("rel.duty", {8'h0, red_duty, green_duty, blue_duty}, 32'h0);

      // Back-to-back RGB commands, mixed case and both terminators.
      send_line("rgb1", "R7f\015", "...O");
      send_line("rgb2", "G00\012", "...O");
      send_line("rgb3", "BFF\015", "...O");
      chk("rgb.red", red_duty, 32'h7F);
      chk("rgb.green", green_duty, 32'h00);
      chk("rgb.blue", blue_duty, 32'hFF);
      chk("rgb.rxcnt", rx_count, 32'd12);
      chk("rgb.errcnt", err_count, 32'd0);

      // Data presented without valid is not consumed.
      rx_valid = 1'b0;
      rx_data  = 8'h52;
      tick();
      tick();
      chk("idle.rxcnt", rx_count, 32'd12);

      // Unknown command skips to end of line, then a lowercase command works.
      send_line("skip", "Q12\015", "E...");
      send_line("low", "r0A\015", "...O");
      chk("low.red", red_duty, 32'h0A);
      chk("low.errcnt", err_count, 32'd1);
      chk("low.rxcnt", rx_count, 32'd20);

      // Too few and too many digits.
      send_line("few", "R5\015", "..E");
      send_line("many", "G123\015", "...E.");
      chk("len.red", red_duty, 32'h0A);
      chk("len.green", green_duty, 32'h00);
      chk("len.errcnt", err_count, 32'd3);
      chk("len.rxcnt", rx_count, 32'd28);

      // Fresh reset, set all to 0x55, clear with X, then saturate err_count.
      rx_valid = 1'b0;
      reset    = 1'b0;
      tick();
      reset    = 1'b1;
      tick();
      send_line("s55r", "R55\015", "...O");
      send_line("s55g", "G55\015", "...O");
      send_line("s55b", "B55\015", "...O");
      chk("s55.duty", {8'h0, red_duty, green_duty, blue_duty}, 32'h555555);
      send_line("xall", "x\012", ".O");
      chk("xall.duty", {8'h0, red_duty, green_duty, blue_duty}, 32'h0);
      for (int i = 0; i < 300; i++) begin
         send_line($sformatf("z%0d", i), "Z\015", "E.");
         if (i == 253) chk("sat.254", err_count, 32'd254);
         if (i == 254) chk("sat.255", err_count, 32'd255);
      end
      chk("sat.final", err_count, 32'd255);
      chk("sat.rxcnt", rx_count, 32'd614);

      // Reset in the middle of a command discards it.
      send_line("b33", "B33\015", "...O");
      chk("b33.blue", blue_duty, 32'h33);
      send_line("b4", "B4", "..");
      rx_valid = 1'b0;
      reset    = 1'b0;
      tick();
      tick();
      chk("mid.blue", blue_duty, 32'h0);
      chk("mid.ready", {31'b0, rx_ready}, 32'h0);
      reset = 1'b1;
      tick();
      send_line("mid.cr", "\015", ".");
      chk("mid.blue2", blue_duty, 32'h0);
      chk("mid.rxcnt", rx_count, 32'd1);
      chk("mid.errcnt", err_count, 32'd0);
      rx_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
